i_wishbone_master: RTL and testbench
====================================

Name: i_wishbone_master

Overview:
- Synthesizable pipelined Wishbone (B4) master engine.
- Takes a stream of single-beat requests (address, data, select, write) grouped into bus cycles by a "last" flag and drives them onto a pipelined Wishbone bus.
- Returns one response per beat (read data or error).
- Used wherever a block must act as a Wishbone bus master: CPU register port of the switch top, endpoint control, and 16-bit fabric source.

Parameters:
- g_addr_width, 32, width of adr_o and req_adr_i.
- g_data_width, 32, width of data buses; must be 16 or 32. Select width is g_data_width/8.
- g_max_outstanding, 16, maximum issued-but-unacknowledged beats; power of two, at most 256.

Ports:
- clk_sys_i, in, 1, system clock; all logic on rising edge.
- rst_n_i, in, 1, reset, synchronous, active-low.
- cfg_addr_gran_i, in, 1, 0 = WORD (adr_o = req_adr_i >> log2(g_data_width/8)), 1 = BYTE (adr_o = req_adr_i unchanged).
- req_valid_i, in, 1, request present.
- req_ready_o, out, 1, request accepted this cycle when high together with req_valid_i.
- req_adr_i, in, g_addr_width, byte address.
- req_dat_i, in, g_data_width, write data.
- req_sel_i, in, g_data_width/8, byte select.
- req_we_i, in, 1, 1 = write.
- req_last_i, in, 1, final beat of the bus cycle.
- rsp_valid_o, out, 1, one-cycle response pulse.
- rsp_dat_o, out, g_data_width, read data (dat_i captured).
- rsp_err_o, out, 1, beat ended with err_i or rty_i.
- busy_o, out, 1, cyc_o high or request pending.
- proto_err_o, out, 1, sticky: termination received with zero outstanding.
- adr_o, out, g_addr_width.
- dat_o, out, g_data_width.
- sel_o, out, g_data_width/8.
- we_o, out, 1.
- cyc_o, out, 1.
- stb_o, out, 1.
- dat_i, in, g_data_width.
- ack_i, in, 1.
- err_i, in, 1.
- rty_i, in, 1.
- stall_i, in, 1.

Behaviour:
- All outputs registered. Reset values: cyc_o = stb_o = we_o = 0; adr_o, dat_o, sel_o = 0; rsp_valid_o = rsp_err_o = 0; rsp_dat_o = 0; proto_err_o = 0; outstanding counter = 0; FSM = IDLE.
- FSM states:
  - IDLE: cyc_o = 0. Accepting a request loads the bus registers and sets cyc_o = stb_o = 1 on the next edge. Go to ISSUE, or to DRAIN if req_last_i.
  - ISSUE: cyc_o = 1. A beat is issued on an edge where stb_o & !stall_i.
    - If a new request is accepted on that edge, the bus registers reload and stb_o stays 1 (back-to-back, one beat per cycle).
    - Otherwise stb_o drops; cyc_o stays 1 through the request gap.
    - Accepting a request with req_last_i moves to DRAIN after that beat's stb is loaded.
  - DRAIN: no new requests accepted (req_ready_o = 0). Hold stb_o until the last beat is issued, then wait until outstanding = 0. cyc_o drops on the edge where the final termination is counted; go to IDLE. Minimum one IDLE cycle between bus cycles.
- req_ready_o (combinational from state) = (state = IDLE) or (state = ISSUE and (!stb_o or !stall_i) and outstanding + pending < g_max_outstanding).
- While stb_o & stall_i: adr_o, dat_o, sel_o, we_o held stable.
- we_o may change between beats within one cycle.
- Outstanding counter:
  - +1 per issued beat; −1 per ack_i|err_i|rty_i while cyc_o.
  - Simultaneous issue and termination leaves it unchanged.
  - Never wraps: a termination at 0 is ignored and sets proto_err_o.
- Terminations arriving with cyc_o = 0 are ignored.
- Responses:
  - Each counted termination produces rsp_valid_o one cycle later, with rsp_dat_o = dat_i sampled on that edge and rsp_err_o = err_i|rty_i.
  - Responses are in issue order.
  - ack_i taking priority is not needed; ack_i together with err_i reports err.
- Synchronous reset mid-cycle: next edge forces cyc_o = stb_o = 0, clears counter and FSM. Outstanding responses are discarded.

Decomposition:
- Package wb_master_pkg: type t_wb_addr_gran (WORD = 0, BYTE = 1); function f_log2 for the address shift.
- No sub-module; the FSM, counter and datapath fit in one module.

Test Plan:
- BYTE gran, single write adr 0x0000_1004 dat 0xDEADBEEF sel 0xF last=1, ack 1 cycle later: cyc high exactly 2 cycles, adr_o = 0x1004, one rsp_valid with rsp_err = 0, then busy_o = 0.
- WORD gran, read adr 0x1004: adr_o = 0x401; dat_i = 0x12345678 with ack gives rsp_dat_o = 0x12345678.
- Burst of 4 writes with stall_i high 3 cycles on beat 2: adr/dat held during stall, 4 beats issued, outstanding peaks at ≤ 4, cyc drops on 4th ack, 4 responses in order.
- g_max_outstanding = 2, slave withholds ack: req_ready_o low after 2 issued beats; resumes after first ack.
- err_i on beat 2 of 3 and rty_i on beat 3: rsp_err sequence 0, 1, 1; cycle still completes.
- Spurious ack_i with cyc_o = 0: no response, proto_err_o stays 0. Ack with cyc high but 0 outstanding sets proto_err_o = 1. rst_n_i low mid-burst drops cyc_o next edge.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared types and helpers for the pipelined Wishbone B4 master engine.
package wb_master_pkg;

  typedef enum logic {
    WORD = 1'b0,
    BYTE = 1'b1
  } t_wb_addr_gran;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } t_wb_state;

  // Ceiling log2, evaluated at elaboration for shifts and counter widths.
  function automatic int f_log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/i_wishbone_master.sv
// Pipelined Wishbone B4 master: turns a stream of single-beat requests grouped
// by a last flag into bus cycles and returns one response per beat.
module i_wishbone_master
  import wb_master_pkg::*;
#(
  parameter int g_addr_width      = 32,
  parameter int g_data_width      = 32,
  parameter int g_max_outstanding = 16
) (
  input  logic                      clk_sys_i,
  input  logic                      rst_n_i,
  input  logic                      cfg_addr_gran_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [g_addr_width-1:0]   req_adr_i,
  input  logic [g_data_width-1:0]   req_dat_i,
  input  logic [g_data_width/8-1:0] req_sel_i,
  input  logic                      req_we_i,
  input  logic                      req_last_i,
  output logic                      rsp_valid_o,
  output logic [g_data_width-1:0]   rsp_dat_o,
  output logic                      rsp_err_o,
  output logic                      busy_o,
  output logic                      proto_err_o,
  output logic [g_addr_width-1:0]   adr_o,
  output logic [g_data_width-1:0]   dat_o,
  output logic [g_data_width/8-1:0] sel_o,
  output logic                      we_o,
  output logic                      cyc_o,
  output logic                      stb_o,
  input  logic [g_data_width-1:0]   dat_i,
  input  logic                      ack_i,
  input  logic                      err_i,
  input  logic                      rty_i,
  input  logic                      stall_i
);

  localparam int c_adr_shift = f_log2(g_data_width / 8);
  localparam int c_cnt_width = f_log2(g_max_outstanding) + 1;

  t_wb_state                 state;
  t_wb_state                 state_nxt;
  logic                      cyc_nxt;
  logic                      stb_nxt;
  logic [c_cnt_width-1:0]    outstanding;
  logic [c_cnt_width-1:0]    outstanding_nxt;
  logic [c_cnt_width:0]      inflight;
  logic                      accept;
  logic                      issue;
  logic                      term;
  logic                      counted;
  logic [g_addr_width-1:0]   adr_conv;

  assign issue    = stb_o & ~stall_i;
  assign term     = cyc_o & (ack_i | err_i | rty_i);
  // A termination with nothing outstanding is a slave protocol violation.
  assign counted  = term & (outstanding != '0);
  assign inflight = {1'b0, outstanding} + (c_cnt_width + 1)'(stb_o);
  assign accept   = req_valid_i & req_ready_o;
  assign busy_o   = cyc_o | req_valid_i;

  assign adr_conv = (t_wb_addr_gran'(cfg_addr_gran_i) == BYTE) ?
                    req_adr_i : (req_adr_i >> c_adr_shift);

  assign outstanding_nxt = outstanding + c_cnt_width'(issue) - c_cnt_width'(counted);

  always_comb begin
    req_ready_o = 1'b0;
    case (state)
      S_IDLE:  req_ready_o = 1'b1;
      S_ISSUE: req_ready_o = (~stb_o | ~stall_i) &&
                             (inflight < (c_cnt_width + 1)'(g_max_outstanding));
      default: req_ready_o = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_o;
    stb_nxt   = stb_o & ~issue;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cyc_nxt   = 1'b1;
          stb_nxt   = 1'b1;
          state_nxt = req_last_i ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          stb_nxt = 1'b1;
          if (req_last_i) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Close the cycle on the edge that retires the final beat.
        if (!stb_nxt && outstanding_nxt == '0) begin
          cyc_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        cyc_nxt   = 1'b0;
        stb_nxt   = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      outstanding <= '0;
    end else begin
      state       <= state_nxt;
      cyc_o       <= cyc_nxt;
      stb_o       <= stb_nxt;
      outstanding <= outstanding_nxt;
    end
  end

  // Bus registers only reload on accept, which keeps them stable under stall.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      adr_o <= '0;
      dat_o <= '0;
      sel_o <= '0;
      we_o  <= 1'b0;
    end else if (accept) begin
      adr_o <= adr_conv;
      dat_o <= req_dat_i;
      sel_o <= req_sel_i;
      we_o  <= req_we_i;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= '0;
      proto_err_o <= 1'b0;
    end else begin
      rsp_valid_o <= counted;
      rsp_err_o   <= counted & (err_i | rty_i);
      if (counted) rsp_dat_o <= dat_i;
      if (term && outstanding == '0) proto_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i_wishbone_master.sv
// Randomised and directed bench for i_wishbone_master against a beat-level
// transaction model (pending/outstanding beats and expected responses).
module tb_i_wishbone_master;

  localparam int MAX_OUT = 2;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        cfg_addr_gran_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_adr_i;
  logic [31:0] req_dat_i;
  logic [3:0]  req_sel_i;
  logic        req_we_i;
  logic        req_last_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic        proto_err_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        cyc_o;
  logic        stb_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;
  logic        stall_i;

  i_wishbone_master #(
    .g_addr_width(32),
    .g_data_width(32),
    .g_max_outstanding(MAX_OUT)
  ) dut (
    .clk_sys_i(clk), .rst_n_i(rst_n), .cfg_addr_gran_i(cfg_addr_gran_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_adr_i(req_adr_i),
    .req_dat_i(req_dat_i), .req_sel_i(req_sel_i), .req_we_i(req_we_i),
    .req_last_i(req_last_i), .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o), .proto_err_o(proto_err_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o), .cyc_o(cyc_o),
    .stb_o(stb_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i),
    .stall_i(stall_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  // Drive values for the next cycle.
  logic        d_valid, d_we, d_last, d_ack, d_err, d_rty, d_stall, d_gran;
  logic [31:0] d_adr, d_dat, d_dati;
  logic [3:0]  d_sel;

  // Transaction model state.
  bit          m_open, m_closing, m_proto;
  int          m_out;
  beat_t       m_pend[$];
  bit          exp_rv, exp_rerr;
  logic [31:0] exp_rdat;

  // Observation logs for directed tests.
  bit          acc;
  int          rsp_seen;
  int          cyc_hi;
  bit          adr_cap_done;
  logic [31:0] adr_cap;
  bit          rsp_err_log[$];
  logic [31:0] rsp_dat_log[$];
  bit          ready_log[$];
  int          term_plan[$];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic driveInputs();
    cfg_addr_gran_i = d_gran;
    req_valid_i     = d_valid;
    req_adr_i       = d_adr;
    req_dat_i       = d_dat;
    req_sel_i       = d_sel;
    req_we_i        = d_we;
    req_last_i      = d_last;
    ack_i           = d_ack;
    err_i           = d_err;
    rty_i           = d_rty;
    stall_i         = d_stall;
    dat_i           = d_dati;
  endtask

  task automatic idle();
    d_valid = 0; d_we = 0; d_last = 0; d_ack = 0; d_err = 0; d_rty = 0; d_stall = 0;
    d_adr = '0; d_dat = '0; d_sel = '0; d_dati = '0;
  endtask

  task automatic clearModel();
    m_open = 0; m_closing = 0; m_proto = 0; m_out = 0; m_pend.delete();
    exp_rv = 0; exp_rerr = 0; exp_rdat = '0;
  endtask

  task automatic clearLogs();
    rsp_seen = 0; cyc_hi = 0; adr_cap_done = 0; adr_cap = '0;
    rsp_err_log.delete(); rsp_dat_log.delete(); ready_log.delete();
  endtask

  // One clock cycle: check registered outputs, drive d_*, advance the model.
  task automatic applyStimulus();
    bit exp_ready, issue, term, counted;
    checkOutput("cyc", cyc_o, m_open);
    checkOutput("stb", stb_o, m_pend.size() != 0);
    if (m_pend.size() != 0) begin
      checkOutput("adr", adr_o, m_pend[0].adr);
      checkOutput("dat", dat_o, m_pend[0].dat);
      checkOutput("sel", sel_o, m_pend[0].sel);
      checkOutput("we", we_o, m_pend[0].we);
    end
    checkOutput("rsp_valid", rsp_valid_o, exp_rv);
    if (exp_rv) begin
      checkOutput("rsp_dat", rsp_dat_o, exp_rdat);
      checkOutput("rsp_err", rsp_err_o, exp_rerr);
    end
    if (rsp_valid_o) begin
      rsp_seen++;
      rsp_err_log.push_back(rsp_err_o);
      rsp_dat_log.push_back(rsp_dat_o);
    end
    checkOutput("proto_err", proto_err_o, m_proto);
    if (cyc_o) cyc_hi++;
    if (stb_o && !adr_cap_done) begin
      adr_cap = adr_o;
      adr_cap_done = 1;
    end

    driveInputs();
    #1;
    exp_ready = !m_open || (!m_closing && (m_pend.size() == 0 || !d_stall) &&
                            (m_out + m_pend.size() < MAX_OUT));
    ready_log.push_back(req_ready_o);
    checkOutput("req_ready", req_ready_o, exp_ready);
    checkOutput("busy", busy_o, m_open || d_valid);

    acc     = d_valid && exp_ready;
    issue   = (m_pend.size() != 0) && !d_stall;
    term    = m_open && (d_ack || d_err || d_rty);
    counted = term && (m_out > 0);
    if (term && m_out == 0) m_proto = 1;
    exp_rv = counted;
    if (counted) begin
      exp_rdat = d_dati;
      exp_rerr = d_err || d_rty;
    end
    if (issue) begin
      void'(m_pend.pop_front());
      m_out++;
    end
    if (counted) m_out--;
    if (acc) begin
      m_pend.push_back('{adr: (d_gran ? d_adr : (d_adr >> 2)), dat: d_dat, sel: d_sel, we: d_we});
      m_open = 1;
      if (d_last) m_closing = 1;
    end
    if (m_closing && m_pend.size() == 0 && m_out == 0) begin
      m_open = 0;
      m_closing = 0;
    end
    @(negedge clk);
  endtask

  task automatic resetCycle();
    idle();
    rst_n = 0;
    driveInputs();
    @(negedge clk);
    clearModel();
    rst_n = 1;
  endtask

  // Sends n beats with a scripted stall window, then answers every beat.
  task automatic runBurst(input int n, input bit we, input logic [31:0] base,
                          input logic [31:0] dbase, input logic [31:0] dibase,
                          input int stall0, input int stall_len, input int hold_until);
    int sent = 0;
    int cyc = 0;
    int nterm = 0;
    int kind;
    while ((sent < n || m_open) && cyc < 200) begin
      idle();
      if (sent < n) begin
        d_valid = 1; d_adr = base + 32'(4 * sent); d_dat = dbase + 32'(sent);
        d_sel = 4'hF; d_we = we; d_last = (sent == n - 1);
      end
      d_stall = (cyc >= stall0) && (cyc < stall0 + stall_len);
      if (m_out > 0 && cyc >= hold_until) begin
        kind = (nterm < term_plan.size()) ? term_plan[nterm] : 0;
        d_ack = (kind == 0); d_err = (kind == 1); d_rty = (kind == 2);
        d_dati = dibase + 32'(nterm);
        nterm++;
      end
      applyStimulus();
      if (acc) sent++;
      cyc++;
    end
    idle();
    applyStimulus();
    checkOutput("burst_done_cyc", cyc_o, 0);
  endtask

  task automatic randomPhase(input int ncyc);
    int burst_left = 0;
    bit have_beat = 0;
    bit finishing = 0;
    int budget = 0;
    int r;
    beat_t b;
    bit b_gran = 0;
    b = '0;
    while (budget < 500 && (!finishing || burst_left > 0 || m_open)) begin
      if (budget == 0 && ncyc <= 0) finishing = 1;
      idle();
      if (!have_beat && (!finishing || burst_left > 0)) begin
        if (burst_left == 0) burst_left = $urandom_range(1, 5);
        b.adr = $urandom; b.dat = $urandom; b.sel = 4'($urandom_range(0, 15));
        b.we = 1'($urandom_range(0, 1)); b_gran = 1'($urandom_range(0, 1));
        have_beat = 1;
      end
      if (have_beat) begin
        d_valid = finishing || ($urandom_range(0, 3) != 0);
        d_adr = b.adr; d_dat = b.dat; d_sel = b.sel; d_we = b.we;
        d_last = (burst_left == 1); d_gran = b_gran;
      end
      d_stall = !finishing && ($urandom_range(0, 3) == 0);
      if (m_out > 0 && (finishing || $urandom_range(0, 1) == 1)) begin
        r = $urandom_range(0, 19);
        d_err = (r == 0) || (r == 2);
        d_rty = (r == 1);
        d_ack = (r >= 2);
      end else if (!m_open && $urandom_range(0, 7) == 0) begin
        d_ack = 1;
      end
      d_dati = $urandom;
      applyStimulus();
      if (acc) begin
        have_beat = 0;
        burst_left--;
      end
      ncyc--;
      if (finishing) budget++;
    end
    idle();
    applyStimulus();
    checkOutput("rand_drain_cyc", cyc_o, 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    d_gran = 1;
    idle();
    clearModel();
    clearLogs();
    rst_n = 0;
    driveInputs();
    repeat (3) @(negedge clk);
    checkOutput("rst_cyc", cyc_o, 0);
    checkOutput("rst_stb", stb_o, 0);
    checkOutput("rst_we", we_o, 0);
    checkOutput("rst_adr", adr_o, 0);
    checkOutput("rst_dat", dat_o, 0);
    checkOutput("rst_sel", sel_o, 0);
    checkOutput("rst_rsp_valid", rsp_valid_o, 0);
    checkOutput("rst_rsp_err", rsp_err_o, 0);
    checkOutput("rst_rsp_dat", rsp_dat_o, 0);
    checkOutput("rst_proto", proto_err_o, 0);
    rst_n = 1;

    $display("[TB] byte-granular single write");
    clearLogs(); d_gran = 1;
    runBurst(1, 1, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    checkOutput("t1_cyc_cycles", cyc_hi, 2);
    checkOutput("t1_adr", adr_cap, 32'h1004);
    checkOutput("t1_rsp_count", rsp_seen, 1);
    checkOutput("t1_rsp_err", rsp_err_log.size() > 0 ? rsp_err_log[0] : 1'b1, 0);
    checkOutput("t1_busy", busy_o, 0);

    $display("[TB] word-granular read");
    clearLogs(); d_gran = 0;
    runBurst(1, 0, 32'h0000_1004, 32'h0, 32'h1234_5678, 0, 0, 0);
    checkOutput("t2_adr", adr_cap, 32'h401);
    checkOutput("t2_rsp_dat", rsp_dat_log.size() > 0 ? rsp_dat_log[0] : 32'h0, 32'h1234_5678);

    $display("[TB] four-beat burst with stall");
    clearLogs(); d_gran = 1;
    runBurst(4, 1, 32'h0000_2000, 32'hB000_0000, 32'h6000_0000, 2, 3, 0);
    checkOutput("t3_rsp_count", rsp_seen, 4);
    for (int k = 0; k < 4; k++)
      checkOutput("t3_rsp_order", k < rsp_dat_log.size() ? rsp_dat_log[k] : 32'h0, 32'h6000_0000 + 32'(k));

    $display("[TB] outstanding limit");
    clearLogs();
    runBurst(3, 0, 32'h0000_3000, 32'h0, 32'h7000_0000, 0, 0, 4);
    checkOutput("t4_ready_blocked", ready_log.size() > 3 ? ready_log[3] : 1'b1, 0);
    checkOutput("t4_ready_resumed", ready_log.size() > 5 ? ready_log[5] : 1'b0, 1);
    checkOutput("t4_rsp_count", rsp_seen, 3);

    $display("[TB] err and rty terminations");
    clearLogs();
    term_plan = '{0, 1, 2};
    runBurst(3, 0, 32'h0000_4000, 32'h0, 32'h8000_0000, 0, 0, 0);
    term_plan.delete();
    checkOutput("t5_rsp_count", rsp_seen, 3);
    for (int k = 0; k < 3; k++)
      checkOutput("t5_rsp_err", k < rsp_err_log.size() ? rsp_err_log[k] : 1'bx, (k == 0) ? 1'b0 : 1'b1);

    $display("[TB] terminations outside a cycle");
    clearLogs(); idle(); d_ack = 1;
    repeat (3) applyStimulus();
    idle();
    applyStimulus();
    checkOutput("t6_no_rsp", rsp_seen, 0);
    checkOutput("t6_proto_clear", proto_err_o, 0);

    $display("[TB] randomised traffic");
    randomPhase(3000);

    $display("[TB] termination with nothing outstanding");
    clearLogs(); idle();
    d_valid = 1; d_adr = 32'h5000; d_last = 1; d_sel = 4'hF;
    applyStimulus();
    idle(); d_ack = 1;
    applyStimulus();
    runBurst(0, 0, 32'h0, 32'h0, 32'h9000_0000, 0, 0, 0);
    checkOutput("t7_proto_set", proto_err_o, 1);

    $display("[TB] reset during burst");
    clearLogs();
    for (int k = 0; k < 3; k++) begin
      idle();
      d_valid = 1; d_adr = 32'h6000 + 32'(4 * k); d_dat = 32'(k); d_sel = 4'hF; d_we = 1;
      applyStimulus();
    end
    resetCycle();
    checkOutput("t8_cyc", cyc_o, 0);
    checkOutput("t8_stb", stb_o, 0);
    checkOutput("t8_proto", proto_err_o, 0);
    idle();
    applyStimulus();
    d_ack = 1;
    applyStimulus();
    idle();
    applyStimulus();
    checkOutput("t8_no_rsp", rsp_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
